// File: rtl/rv64_lsu_pkg.sv
// Shared types for the RV64 load/store unit: funct3 encodings, FSM states,
// response error codes and the acceptance-time legality check.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;
    localparam logic [2:0] SD = 3'b011;

    localparam logic [1:0] LSU_OK       = 2'b00;
    localparam logic [1:0] LSU_MISALIGN = 2'b01;
    localparam logic [1:0] LSU_ILLEGAL  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        REQ_LO,
        WAIT_LO,
        REQ_HI,
        WAIT_HI,
        RESP
    } lsu_state_t;

    // Illegal encodings win over misalignment; funct3[1:0] is log2 of the access size.
    function automatic logic [1:0] lsuCheck(input logic isStore, input logic [2:0] funct3,
                                            input logic [2:0] addrLo);
        logic misalign;
        case (funct3[1:0])
            2'b01:   misalign = addrLo[0];
            2'b10:   misalign = |addrLo[1:0];
            2'b11:   misalign = |addrLo;
            default: misalign = 1'b0;
        endcase
        if (isStore ? funct3[2] : (funct3 == 3'b111)) return LSU_ILLEGAL;
        if (misalign) return LSU_MISALIGN;
        return LSU_OK;
    endfunction

endpackage

// File: rtl/rv64_lsu_if.sv
// Word-wide memory port of the load/store unit. The LSU is the master; the
// memory (or bus adapter) is the slave.
interface rv64_lsu_if #(
    parameter int MEM_AW = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/rv64_lsu_align.sv
// Combinational data path of the LSU: places store bytes/halves on the word
// lanes with strobes, and extracts/extends load data from the returned word(s).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  stSize,
    input  logic [1:0]  stOffs,
    input  logic [31:0] stData,
    output logic [31:0] stWord,
    output logic [3:0]  stStrb,
    input  logic [2:0]  ldFunct3,
    input  logic [1:0]  ldOffs,
    input  logic [31:0] ldRdata,
    input  logic [31:0] ldLoWord,
    output logic [63:0] ldData
);
    logic [15:0] shifted;

    // Replicating the datum lets the strobes alone pick the target lanes.
    always_comb begin
        stWord = stData;
        stStrb = 4'b1111;
        case (stSize)
            2'b00: begin
                stWord = {4{stData[7:0]}};
                stStrb = 4'b0001 << stOffs;
            end
            2'b01: begin
                stWord = {2{stData[15:0]}};
                stStrb = 4'b0011 << stOffs;
            end
            default: ;
        endcase
    end

    assign shifted = 16'(ldRdata >> {ldOffs, 3'b000});

    always_comb begin
        ldData = '0;
        case (ldFunct3)
            LB:      ldData = {{56{shifted[7]}}, shifted[7:0]};
            LH:      ldData = {{48{shifted[15]}}, shifted[15:0]};
            LW:      ldData = {{32{ldRdata[31]}}, ldRdata};
            LD:      ldData = {ldRdata, ldLoWord};
            LBU:     ldData = {56'd0, shifted[7:0]};
            LHU:     ldData = {48'd0, shifted[15:0]};
            LWU:     ldData = {32'd0, ldRdata};
            default: ldData = '0;
        endcase
    end

endmodule

// File: rtl/rv64_lsu.sv
// RV64 load/store unit: one request at a time onto a 32-bit memory port,
// doublewords split in two. Optional tohost capture with LSU_TOHOST_EN.
module rv64_lsu
    import lsu_pkg::*;
#(
    parameter int          MEM_AW      = 32,
    parameter logic [63:0] TOHOST_ADDR = 64'h0000_0000_8000_1000
) (
    input  logic        clk,
    input  logic        reset,
    // req: taken when req_valid && req_ready; rsp: held until rsp_valid && rsp_ready.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic [1:0]  rsp_err,
    rv64_lsu_if.master  mem,
`ifdef LSU_TOHOST_EN
    output logic        tohost_valid,
    output logic [63:0] tohost_data,
`endif
    output lsu_state_t  dbgState
);
    lsu_state_t        state;
    logic              rStore;
    logic [2:0]        rFunct3;
    logic [MEM_AW-1:0] rAddr;
    logic [31:0]       rWdataHi;
    logic [31:0]       loWord;

    logic [1:0]        acceptErr;
    logic [31:0]       stWord;
    logic [3:0]        stStrb;
    logic [63:0]       ldData;
    logic [MEM_AW-1:0] hiWordAddr;
    logic              isDouble;

    assign acceptErr  = lsuCheck(req_store, req_funct3, req_addr[2:0]);
    assign hiWordAddr = {rAddr[MEM_AW-1:2] + (MEM_AW-2)'(1), 2'b00};
    assign isDouble   = (rFunct3[1:0] == 2'b11);
    assign dbgState   = state;

`ifdef LSU_TOHOST_EN
    logic tohostHit;
    assign tohostHit = req_store && (req_funct3 == SD) && (req_addr == TOHOST_ADDR);
`else
    logic unusedBits;
    assign unusedBits = ^{req_addr[63:MEM_AW], TOHOST_ADDR};
`endif

    lsu_align uAlign (
        .stSize   (req_funct3[1:0]),
        .stOffs   (req_addr[1:0]),
        .stData   (req_wdata[31:0]),
        .stWord   (stWord),
        .stStrb   (stStrb),
        .ldFunct3 (rFunct3),
        .ldOffs   (rAddr[1:0]),
        .ldRdata  (mem.mem_rdata),
        .ldLoWord (loWord),
        .ldData   (ldData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= LSU_OK;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wstrb <= '0;
            rStore        <= 1'b0;
            rFunct3       <= '0;
            rAddr         <= '0;
            rWdataHi      <= '0;
            loWord        <= '0;
`ifdef LSU_TOHOST_EN
            tohost_valid  <= 1'b0;
            tohost_data   <= '0;
`endif
        end else begin
`ifdef LSU_TOHOST_EN
            tohost_valid <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        rStore    <= req_store;
                        rFunct3   <= req_funct3;
                        rAddr     <= req_addr[MEM_AW-1:0];
                        rWdataHi  <= req_wdata[63:32];
                        if (acceptErr != LSU_OK) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= acceptErr;
                            rsp_data  <= '0;
                        end
`ifdef LSU_TOHOST_EN
                        else if (tohostHit) begin
                            tohost_valid <= 1'b1;
                            tohost_data  <= req_wdata;
                            state        <= RESP;
                            rsp_valid    <= 1'b1;
                            rsp_err      <= LSU_OK;
                            rsp_data     <= '0;
                        end
`endif
                        else begin
                            state         <= REQ_LO;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= req_store;
                            mem.mem_addr  <= {req_addr[MEM_AW-1:2], 2'b00};
                            mem.mem_wdata <= req_store ? stWord : 32'd0;
                            mem.mem_wstrb <= req_store ? stStrb : 4'd0;
                        end
                    end
                end
                REQ_LO: begin
                    if (mem.mem_gnt) begin
                        if (rStore && isDouble) begin
                            state         <= REQ_HI;
                            mem.mem_addr  <= hiWordAddr;
                            mem.mem_wdata <= rWdataHi;
                            mem.mem_wstrb <= 4'b1111;
                        end else if (rStore) begin
                            state         <= RESP;
                            mem.mem_req   <= 1'b0;
                            mem.mem_we    <= 1'b0;
                            mem.mem_wstrb <= 4'd0;
                            rsp_valid     <= 1'b1;
                            rsp_err       <= LSU_OK;
                            rsp_data      <= '0;
                        end else begin
                            state       <= WAIT_LO;
                            mem.mem_req <= 1'b0;
                        end
                    end
                end
                WAIT_LO: begin
                    if (mem.mem_rvalid) begin
                        if (isDouble) begin
                            state        <= REQ_HI;
                            loWord       <= mem.mem_rdata;
                            mem.mem_req  <= 1'b1;
                            mem.mem_addr <= hiWordAddr;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= LSU_OK;
                            rsp_data  <= ldData;
                        end
                    end
                end
                REQ_HI: begin
                    if (mem.mem_gnt) begin
                        mem.mem_req <= 1'b0;
                        if (rStore) begin
                            state         <= RESP;
                            mem.mem_we    <= 1'b0;
                            mem.mem_wstrb <= 4'd0;
                            rsp_valid     <= 1'b1;
                            rsp_err       <= LSU_OK;
                            rsp_data      <= '0;
                        end else begin
                            state <= WAIT_HI;
                        end
                    end
                end
                WAIT_HI: begin
                    if (mem.mem_rvalid) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= LSU_OK;
                        rsp_data  <= ldData;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv64_lsu.sv
// Bench for rv64_lsu: byte-addressed memory responder with random grant/rvalid
// delays, a byte-level reference model and an expected-response queue.
module tb_rv64_lsu;
    import lsu_pkg::*;

    localparam logic [63:0] TOHOST = 64'h0000_0000_8000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_data;
    logic [1:0]  rsp_err;
    lsu_state_t  dbgState;
`ifdef LSU_TOHOST_EN
    logic        tohost_valid;
    logic [63:0] tohost_data;
`endif

    always #5 clk = ~clk;

    rv64_lsu_if #(.MEM_AW(32)) mem ();

    rv64_lsu #(.MEM_AW(32), .TOHOST_ADDR(TOHOST)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .mem        (mem.master),
`ifdef LSU_TOHOST_EN
        .tohost_valid (tohost_valid),
        .tohost_data  (tohost_data),
`endif
        .dbgState   (dbgState)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- memory contents and reference model ----------------
    logic [7:0] memBytes [logic [31:0]];
    logic [7:0] refBytes [logic [31:0]];
    logic [65:0] expQ [$];

    function automatic logic [7:0] initByte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5a;
    endfunction

    function automatic logic [7:0] memByte(input logic [31:0] a);
        return memBytes.exists(a) ? memBytes[a] : initByte(a);
    endfunction

    function automatic logic [7:0] refByte(input logic [31:0] a);
        return refBytes.exists(a) ? refBytes[a] : initByte(a);
    endfunction

    task automatic presetWord(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            memBytes[a + i] = w[8*i +: 8];
            refBytes[a + i] = w[8*i +: 8];
        end
    endtask

    // Returns {err, data}; stores update the golden byte image.
    function automatic logic [65:0] model(input logic st, input logic [2:0] f3,
                                          input logic [63:0] a, input logic [63:0] wd);
        int size;
        logic [63:0] v;
        logic [31:0] ma;
        size = 1 << f3[1:0];
        if (st ? f3[2] : (f3 == 3'b111)) return {2'b10, 64'd0};
        if ((a % 64'(size)) != 0) return {2'b01, 64'd0};
`ifdef LSU_TOHOST_EN
        if (st && f3 == 3'b011 && a == TOHOST) return {2'b00, 64'd0};
`endif
        ma = a[31:0];
        if (st) begin
            for (int i = 0; i < size; i++) refBytes[ma + i] = wd[8*i +: 8];
            return {2'b00, 64'd0};
        end
        v = 64'd0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = refByte(ma + i);
        if (!f3[2] && size < 8 && v[8*size-1])
            for (int i = 8*size; i < 64; i++) v[i] = 1'b1;
        return {2'b00, v};
    endfunction

    // ---------------- memory responder ----------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_acc_t;

    mem_acc_t    memLog [$];
    int          gntDelay = 0;
    int          gntWait = 0;
    int          rvDelay = 1;
    int          rdCnt = 0;
    bit          rdPending = 1'b0;
    bit          inAccess = 1'b0;
    logic [68:0] snap;
    logic [31:0] rdWord;

    initial begin
        mem.mem_gnt    = 1'b0;
        mem.mem_rvalid = 1'b0;
        mem.mem_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            mem.mem_gnt    = 1'b0;
            mem.mem_rvalid = 1'b0;
            mem.mem_rdata  = $urandom;
            if (rdPending) begin
                if (rdCnt == 0) begin
                    mem.mem_rvalid = 1'b1;
                    mem.mem_rdata  = rdWord;
                    rdPending      = 1'b0;
                end else begin
                    rdCnt--;
                end
            end
            if (!mem.mem_req) begin
                inAccess = 1'b0;
            end else begin
                if (!inAccess) begin
                    snap = {mem.mem_addr, mem.mem_we, mem.mem_wdata, mem.mem_wstrb};
                    inAccess = 1'b1;
                end else begin
                    checkVal("mem_hold", {mem.mem_addr, mem.mem_we, mem.mem_wdata, mem.mem_wstrb}, snap);
                end
                if (gntWait > 0) begin
                    gntWait--;
                end else begin
                    mem.mem_gnt = 1'b1;
                    memLog.push_back('{mem.mem_addr, mem.mem_we, mem.mem_wdata, mem.mem_wstrb});
                    if (mem.mem_we) begin
                        for (int i = 0; i < 4; i++)
                            if (mem.mem_wstrb[i]) memBytes[mem.mem_addr + i] = mem.mem_wdata[8*i +: 8];
                    end else begin
                        rdWord    = {memByte(mem.mem_addr + 3), memByte(mem.mem_addr + 2),
                                     memByte(mem.mem_addr + 1), memByte(mem.mem_addr)};
                        rdPending = 1'b1;
                        rdCnt     = rvDelay - 1;
                    end
                    gntWait  = gntDelay;
                    inAccess = 1'b0;
                end
            end
        end
    end

`ifdef LSU_TOHOST_EN
    int          tohostPulses = 0;
    logic [63:0] tohostLast = 64'd0;
    initial forever begin
        @(negedge clk);
        if (tohost_valid) begin
            tohostPulses++;
            tohostLast = tohost_data;
        end
    end
`endif

    // ---------------- driver ----------------
    task automatic runTxn(input string name, input logic st, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] wd, input int g,
                          input int rv, input int hold, output logic [65:0] gotOut);
        logic [65:0] exp;
        logic [65:0] got;
        logic [63:0] memDw;
        logic [63:0] refDw;
        logic [31:0] dwBase;
        int lat;
        int expLat;
        int nAcc;
        bit special;
        exp = model(st, f3, a, wd);
        expQ.push_back(exp);
        special = (exp[65:64] != 2'b00);
`ifdef LSU_TOHOST_EN
        if (st && f3 == 3'b011 && a == TOHOST) special = 1'b1;
`endif
        nAcc   = special ? 0 : ((f3[1:0] == 2'b11) ? 2 : 1);
        expLat = (nAcc == 0) ? 1 : 1 + nAcc * (g + 1 + (st ? 0 : rv));

        @(negedge clk);
        gntDelay = g;
        gntWait  = g;
        rvDelay  = rv;
        memLog.delete();
        checkVal({name, ".req_ready"}, 128'(req_ready), 128'(1));
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;

        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        exp = expQ.pop_front();
        gotOut = 66'd0;
        if (lat == 0) begin
            checkVal({name, ".rsp_timeout"}, 128'(0), 128'(1));
            return;
        end
        checkVal({name, ".latency"}, 128'(lat), 128'(expLat));
        got = {rsp_err, rsp_data};
        gotOut = got;
        checkVal({name, ".rsp"}, 128'(got), 128'(exp));

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkVal({name, ".rsp_hold"}, {rsp_valid, req_ready, rsp_err, rsp_data},
                     {1'b1, 1'b0, got});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkVal({name, ".rsp_done"}, 128'({rsp_valid, req_ready}), 128'(2'b01));

        checkVal({name, ".mem_count"}, 128'(memLog.size()), 128'(nAcc));
        for (int i = 0; i < memLog.size() && i < nAcc; i++) begin
            checkVal({name, ".mem_acc"},
                     {memLog[i].addr, memLog[i].we, (st ? 4'h0 : memLog[i].wstrb)},
                     {({a[31:2], 2'b00} + 32'(4 * i)), st, 4'h0});
        end
        if (st && nAcc > 0) begin
            dwBase = {a[31:3], 3'b000};
            for (int i = 0; i < 8; i++) begin
                memDw[8*i +: 8] = memByte(dwBase + i);
                refDw[8*i +: 8] = refByte(dwBase + i);
            end
            checkVal({name, ".mem_image"}, 128'(memDw), 128'(refDw));
        end
    endtask

    task automatic resetMidTxn();
        @(negedge clk);
        gntDelay = 0;
        gntWait  = 0;
        rvDelay  = 4;
        memLog.delete();
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = LW;
        req_addr   = 64'h8000_0300;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkVal("rst.in_wait_lo", 128'(dbgState), 128'(WAIT_LO));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkVal("rst.quiet", 128'({rsp_valid, req_ready, mem.mem_req}), 128'(3'b010));
        end
    endtask

    // ---------------- main sequence ----------------
    logic [65:0] got;

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("reset.outs",
                 128'({req_ready, rsp_valid, rsp_data, rsp_err, mem.mem_req, mem.mem_we, mem.mem_wstrb}),
                 128'({1'b1, 1'b0, 64'd0, 2'b00, 1'b0, 1'b0, 4'h0}));
        checkVal("reset.state", 128'(dbgState), 128'(IDLE));
        reset = 1'b0;

        runTxn("sw", 1'b1, SW, 64'h8000_0104, 64'h0000_0000_dead_beef, 0, 1, 0, got);
        checkVal("sw.bus", {memLog[0].addr, memLog[0].wstrb, memLog[0].wdata},
                 {32'h8000_0104, 4'hf, 32'hdead_beef});
        checkVal("sw.err", 128'(got[65:64]), 128'(2'b00));

        presetWord(32'h8000_0100, 32'h80ff_0000);
        runTxn("lb", 1'b0, LB, 64'h8000_0103, 64'd0, 0, 1, 0, got);
        checkVal("lb.value", 128'(got), 128'({2'b00, 64'hffff_ffff_ffff_ff80}));
        runTxn("lbu", 1'b0, LBU, 64'h8000_0103, 64'd0, 0, 1, 0, got);
        checkVal("lbu.value", 128'(got), 128'({2'b00, 64'h0000_0000_0000_0080}));

        presetWord(32'h8000_0200, 32'h1122_3344);
        presetWord(32'h8000_0204, 32'h5566_7788);
        runTxn("ld", 1'b0, LD, 64'h8000_0200, 64'd0, 2, 1, 0, got);
        checkVal("ld.value", 128'(got), 128'({2'b00, 64'h5566_7788_1122_3344}));
        checkVal("ld.hi_addr", 128'(memLog[1].addr), 128'(32'h8000_0204));

        runTxn("lw_mis", 1'b0, LW, 64'h8000_0102, 64'd0, 0, 1, 0, got);
        checkVal("lw_mis.err", 128'(got), 128'({2'b01, 64'd0}));
        runTxn("ld_ill", 1'b0, 3'b111, 64'h8000_0108, 64'd0, 0, 1, 0, got);
        checkVal("ld_ill.err", 128'(got), 128'({2'b10, 64'd0}));
        runTxn("st_ill", 1'b1, 3'b101, 64'h8000_0101, 64'd7, 0, 1, 0, got);
        checkVal("st_ill.err", 128'(got), 128'({2'b10, 64'd0}));

        runTxn("sd", 1'b1, SD, 64'h8000_0208, 64'h0123_4567_89ab_cdef, 0, 1, 3, got);
        runTxn("sh", 1'b1, SH, 64'h8000_020e, 64'h0000_0000_0000_a55a, 1, 1, 0, got);
        runTxn("ld2", 1'b0, LD, 64'h8000_0208, 64'd0, 0, 1, 3, got);
        checkVal("ld2.value", 128'(got), 128'({2'b00, 64'ha55a_4567_89ab_cdef}));

        resetMidTxn();

`ifdef LSU_TOHOST_EN
        begin
            int before;
            before = tohostPulses;
            runTxn("tohost", 1'b1, SD, TOHOST, 64'd1, 0, 1, 0, got);
            checkVal("tohost.pulses", 128'(tohostPulses - before), 128'(1));
            checkVal("tohost.data", 128'(tohostLast), 128'(64'd1));
        end
`endif

        for (int n = 0; n < 150; n++) begin
            logic        st;
            logic [2:0]  f3;
            logic [63:0] a;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 64'h8000_0000 + 64'($urandom_range(0, 31)) * 8;
            if ($urandom_range(0, 3) == 0) a = a + 64'($urandom_range(1, 7));
            runTxn("rand", st, f3, a, {$urandom, $urandom}, $urandom_range(0, 2),
                   $urandom_range(1, 3), $urandom_range(0, 2), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
